// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin share of one register-file read mux between NREQ requesters
// ports: clock_i/reset_n_i sync active-low reset; req_i/addr_i per-requester level request and address;
//        stall_i holds the select phase; mux_select_o/mux_data_i drive and return the read mux;
//        grant_o one-hot during select; rdata_o/rvalid_o registered data with one-cycle one-hot valid
module regfile_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int SEL_W   = 5,
  parameter int DATA_W  = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*SEL_W-1:0] addr_i,
  input  logic                  stall_i,
  output logic [SEL_W-1:0]      mux_select_o,
  input  logic [DATA_W-1:0]     mux_data_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [NREQ-1:0]       rvalid_o
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, SEL, RESP} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d, last_q, last_d, pick;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d, win_oh, cand;
  logic found;
  assign win_oh = NREQ'(1) << win_q;
  // the requester just answered may not win back-to-back from RESP
  assign cand = (state_q == RESP) ? (req_i & ~win_oh) : req_i;
  // scan downward so the nearest requester after last_q is written last and wins
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (cand[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        pick = IDX_W'((int'(last_q) + k) % NREQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    last_d = last_q;
    sel_d = sel_q;
    rdata_d = rdata_q;
    rvalid_d = '0;
    if (state_q != SEL) begin
      state_d = found ? SEL : IDLE;
      win_d = found ? pick : win_q;
      sel_d = found ? addr_i[int'(pick)*SEL_W +: SEL_W] : sel_q;
    end else if (!stall_i) begin
      rdata_d = (ZERO_R0 != 0 && sel_q == '0) ? '0 : mux_data_i;
      rvalid_d = win_oh;
      last_d = win_q;
      state_d = RESP;
    end
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      win_q <= '0;
      last_q <= IDX_W'(NREQ - 1);
      sel_q <= '0;
      rdata_q <= '0;
      rvalid_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      last_q <= last_d;
      sel_q <= sel_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign grant_o = (state_q == SEL) ? win_oh : '0;
  assign mux_select_o = sel_q;
  assign rdata_o = rdata_q;
  assign rvalid_o = rvalid_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed checks of arbitration order, latency, r0 zeroing, stall and reset
module tb_regfile_read_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, stall;
  logic [3:0] req, grant, rvalid;
  logic [19:0] addr;
  logic [4:0] msel;
  logic [31:0] mdata, rdata;
  logic [31:0] rf [32];
  int total = 0, bad = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  assign mdata = rf[msel];
  regfile_read_arbiter dut (
    .clock_i(clk), .reset_n_i(rst_n), .req_i(req), .addr_i(addr), .stall_i(stall),
    .mux_select_o(msel), .mux_data_i(mdata), .grant_o(grant), .rdata_o(rdata), .rvalid_o(rvalid)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot", 64'($onehot0(grant) && $onehot0(rvalid) && !(|grant && |rvalid)), 64'd1);
  endtask
  task automatic set_addr(input int i, input logic [4:0] a);
    addr[i*5 +: 5] = a;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
    rf[7] = 32'hDEADBEEF;
    rf[0] = 32'hFFFFFFFF;
    rst_n = 1'b0; req = '0; addr = '0; stall = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", 64'({grant, rvalid, msel, rdata}), 64'd0);
    end
    req = 4'b0001; set_addr(0, 5'd7);
    step();
    chk("s_grant", 64'(grant), 64'h1);
    chk("s_sel", 64'(msel), 64'd7);
    chk("s_rv0", 64'(rvalid), 64'h0);
    req = 4'b0000;
    step();
    chk("s_rvalid", 64'(rvalid), 64'h1);
    chk("s_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("s_grant0", 64'(grant), 64'h0);
    step();
    chk("s_idle", 64'({grant, rvalid}), 64'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_grant", 64'(grant), 64'(4'b0001 << order[n]));
      chk("rr_sel", 64'(msel), 64'(order[n] + 1));
      chk("rr_rv0", 64'(rvalid), 64'h0);
      step();
      chk("rr_rvalid", 64'(rvalid), 64'(4'b0001 << order[n]));
      chk("rr_rdata", 64'(rdata), 64'(32'hA000_0000 | 32'(order[n] + 1)));
      chk("rr_grant0", 64'(grant), 64'h0);
      if (n == 4) req = 4'b0000;
    end
    step();
    chk("rr_idle", 64'({grant, rvalid}), 64'h0);
    req = 4'b0010; set_addr(1, 5'd0);
    step();
    chk("z_grant", 64'(grant), 64'h2);
    chk("z_sel", 64'(msel), 64'd0);
    req = 4'b0000;
    step();
    chk("z_rvalid", 64'(rvalid), 64'h2);
    chk("z_rdata", 64'(rdata), 64'h0);
    step();
    req = 4'b0100; set_addr(2, 5'd9);
    step();
    chk("st_grant", 64'(grant), 64'h4);
    chk("st_sel", 64'(msel), 64'd9);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("st_hold_grant", 64'(grant), 64'h4);
      chk("st_hold_sel", 64'(msel), 64'd9);
      chk("st_hold_rv", 64'(rvalid), 64'h0);
    end
    stall = 1'b0;
    rf[9] = 32'h2222_2222;
    step();
    chk("st_rvalid", 64'(rvalid), 64'h4);
    chk("st_rdata", 64'(rdata), 64'h2222_2222);
    chk("st_grant0", 64'(grant), 64'h0);
    req = 4'b0000;
    step();
    req = 4'b1001; set_addr(3, 5'd5); set_addr(0, 5'd6);
    step();
    chk("r_grant", 64'(grant), 64'h8);
    chk("r_sel", 64'(msel), 64'd5);
    rst_n = 1'b0;
    step();
    chk("r_grant0", 64'(grant), 64'h0);
    chk("r_rv0", 64'(rvalid), 64'h0);
    chk("r_sel0", 64'(msel), 64'd0);
    rst_n = 1'b1;
    step();
    chk("r_grant_req0", 64'(grant), 64'h1);
    chk("r_sel6", 64'(msel), 64'd6);
    chk("r_rv_none", 64'(rvalid), 64'h0);
    req = 4'b0000;
    step();
    chk("r_rvalid", 64'(rvalid), 64'h1);
    chk("r_rdata", 64'(rdata), 64'hA000_0006);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
